// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Operand issue stage in front of the 72-bit ALU. Queues
//                decoded ops in a small FIFO, selects operand B (register or
//                extended immediate), stalls one cycle on a back-to-back
//                dependency and forwards the ALU result, and emits a
//                result-valid/tag/div-by-zero sideband aligned with ALU C.
//  Option      : define ALU_ISSUE_IMM_SEXT_EN to sign-extend the immediate
//                (default build zero-extends it).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_W = 72,
    parameter int IMM_W  = 55,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              in_a_pend,
    input  logic              in_b_pend,
    input  logic [TAG_W-1:0]  in_rd,
    input  logic              wb_ready,
    input  logic [DATA_W-1:0] alu_c,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              res_valid,
    output logic [TAG_W-1:0]  res_rd,
    output logic              res_div0,
    output logic              busy
);

    localparam int                 c_PTR_W  = $clog2(DEPTH);
    localparam int                 c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_OP_DIV = 4'd3;
    localparam logic [3:0]         c_OP_REM = 4'd15;

    // FIFO storage, one array per field
    logic [3:0]        r_q_op   [DEPTH];
    logic [DATA_W-1:0] r_q_a    [DEPTH];
    logic [DATA_W-1:0] r_q_b    [DEPTH];
    logic [IMM_W-1:0]  r_q_imm  [DEPTH];
    logic              r_q_ui   [DEPTH];
    logic              r_q_ap   [DEPTH];
    logic              r_q_bp   [DEPTH];
    logic [TAG_W-1:0]  r_q_rd   [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Issue registers feeding the ALU and the result sideband pipe
    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_p1_valid;
    logic [TAG_W-1:0]  r_p1_rd;
    logic              r_p1_div0;
    logic              r_res_valid;
    logic [TAG_W-1:0]  r_res_rd;
    logic              r_res_div0;
    logic [1:0]        r_inflight;
    logic [DATA_W-1:0] r_last_c;

    logic              w_push;
    logic              w_issue;
    logic              w_fwd_ok;
    logic              w_hazard;
    logic [3:0]        w_h_op;
    logic [DATA_W-1:0] w_h_a;
    logic [DATA_W-1:0] w_h_b;
    logic [IMM_W-1:0]  w_h_imm;
    logic              w_h_ui;
    logic              w_h_ap;
    logic              w_h_bp;
    logic [TAG_W-1:0]  w_h_rd;
    logic [DATA_W-1:0] w_fwd;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_a_eff;
    logic [DATA_W-1:0] w_b_eff;
    logic              w_div0;

    assign in_ready = (r_count < c_DEPTH);
    assign w_push   = in_valid && in_ready;

    assign w_h_op  = r_q_op[r_rd_ptr];
    assign w_h_a   = r_q_a[r_rd_ptr];
    assign w_h_b   = r_q_b[r_rd_ptr];
    assign w_h_imm = r_q_imm[r_rd_ptr];
    assign w_h_ui  = r_q_ui[r_rd_ptr];
    assign w_h_ap  = r_q_ap[r_rd_ptr];
    assign w_h_bp  = r_q_bp[r_rd_ptr];
    assign w_h_rd  = r_q_rd[r_rd_ptr];

    // Forwarding is only safe when the single op in flight is presenting its
    // result right now, or nothing is in flight (last_c holds the result).
    assign w_fwd_ok = (r_inflight == 2'd0) || ((r_inflight == 2'd1) && r_res_valid);
    assign w_hazard = (w_h_ap || (w_h_bp && !w_h_ui)) && !w_fwd_ok;
    assign w_issue  = (r_count != '0) && wb_ready && !w_hazard;

    assign w_fwd = r_res_valid ? alu_c : r_last_c;

`ifdef ALU_ISSUE_IMM_SEXT_EN
    assign w_imm_ext = {{(DATA_W-IMM_W){w_h_imm[IMM_W-1]}}, w_h_imm};
`else
    assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, w_h_imm};
`endif

    assign w_a_eff = w_h_ap ? w_fwd : w_h_a;
    assign w_b_eff = w_h_ui ? w_imm_ext : (w_h_bp ? w_fwd : w_h_b);
    assign w_div0  = ((w_h_op == c_OP_DIV) || (w_h_op == c_OP_REM)) && (w_b_eff == '0);

    // FIFO payload write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_wr_ptr]  <= in_op;
            r_q_a[r_wr_ptr]   <= in_a;
            r_q_b[r_wr_ptr]   <= in_b;
            r_q_imm[r_wr_ptr] <= in_imm;
            r_q_ui[r_wr_ptr]  <= in_use_imm;
            r_q_ap[r_wr_ptr]  <= in_a_pend;
            r_q_bp[r_wr_ptr]  <= in_b_pend;
            r_q_rd[r_wr_ptr]  <= in_rd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ALU operand registers load on issue and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else if (w_issue) begin
            r_alu_op <= w_h_op;
            r_alu_a  <= w_a_eff;
            r_alu_b  <= w_b_eff;
        end
    end

    // Two-stage sideband pipe: stage 1 while the ALU samples, stage 2 aligned with C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid  <= 1'b0;
            r_p1_rd     <= '0;
            r_p1_div0   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_rd    <= '0;
            r_res_div0  <= 1'b0;
        end else begin
            r_p1_valid  <= w_issue;
            r_p1_rd     <= w_h_rd;
            r_p1_div0   <= w_div0;
            r_res_valid <= r_p1_valid;
            r_res_rd    <= r_p1_rd;
            r_res_div0  <= r_p1_div0;
        end
    end

    // In-flight count and the captured last result used for late forwarding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
            r_last_c   <= '0;
        end else begin
            case ({w_issue, r_res_valid})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
            if (r_res_valid) begin
                r_last_c <= alu_c;
            end
        end
    end

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = r_res_valid;
    assign res_rd    = r_res_rd;
    assign res_div0  = r_res_div0;
    assign busy      = (r_count != '0) || (r_inflight != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage with a stub ALU
//                (C = A + B + op, registered) and a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int DATA_W = 72;
    localparam int IMM_W  = 55;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_op = '0;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [IMM_W-1:0]  in_imm = '0;
    logic              in_use_imm = 1'b0;
    logic              in_a_pend = 1'b0;
    logic              in_b_pend = 1'b0;
    logic [TAG_W-1:0]  in_rd = '0;
    logic              wb_ready = 1'b0;
    logic [DATA_W-1:0] alu_c = '0;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              res_valid;
    logic [TAG_W-1:0]  res_rd;
    logic              res_div0;
    logic              busy;

    alu_issue_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_a_pend(in_a_pend), .in_b_pend(in_b_pend), .in_rd(in_rd),
        .wb_ready(wb_ready), .alu_c(alu_c),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .res_valid(res_valid), .res_rd(res_rd), .res_div0(res_div0), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub ALU: registered result
    always @(posedge clk) alu_c <= alu_a + alu_b + {68'd0, alu_op};

    typedef struct {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [IMM_W-1:0]  imm;
        logic              ui;
        logic              ap;
        logic              bp;
        logic [TAG_W-1:0]  rd;
    } op_t;

    typedef struct {
        int                cyc;
        logic [TAG_W-1:0]  rd;
        logic              div0;
        logic [DATA_W-1:0] res;
    } fl_t;

    op_t               q[$];
    fl_t               fl[$];
    int                cyc = 0;
    logic [DATA_W-1:0] last_res = '0;
    logic [3:0]        m_op = '0;
    logic [DATA_W-1:0] m_a = '0;
    logic [DATA_W-1:0] m_b = '0;
    bit                m_acc;
    bit                m_iss;
    int                errors = 0;
    int                checks = 0;

    function automatic logic [DATA_W-1:0] ext(input logic [IMM_W-1:0] v);
`ifdef ALU_ISSUE_IMM_SEXT_EN
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
`else
        return {{(DATA_W-IMM_W){1'b0}}, v};
`endif
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=progress", tag);
    endtask

    // One clock: check outputs at negedge, predict, then advance the model at posedge
    task automatic step();
        op_t               h;
        op_t               cur;
        fl_t               e;
        logic [DATA_W-1:0] av;
        logic [DATA_W-1:0] bv;
        bit                rv;
        bit                fwd_ok;
        bit                haz;
        @(negedge clk);
        while (fl.size() > 0 && fl[0].cyc + 1 < cyc) void'(fl.pop_front());
        rv     = (fl.size() > 0) && (fl[0].cyc + 1 == cyc);
        fwd_ok = (fl.size() == 0) || (fl.size() == 1 && rv);
        chk("in_ready",  72'(in_ready),  72'(q.size() < DEPTH));
        chk("busy",      72'(busy),      72'(q.size() != 0 || fl.size() != 0));
        chk("res_valid", 72'(res_valid), 72'(rv));
        if (rv) begin
            chk("res_rd",   72'(res_rd),   72'(fl[0].rd));
            chk("res_div0", 72'(res_div0), 72'(fl[0].div0));
            chk("alu_c",    alu_c,         fl[0].res);
        end
        chk("alu_op", 72'(alu_op), 72'(m_op));
        chk("alu_a",  alu_a,       m_a);
        chk("alu_b",  alu_b,       m_b);
        cur   = '{in_op, in_a, in_b, in_imm, in_use_imm, in_a_pend, in_b_pend, in_rd};
        m_acc = in_valid && (q.size() < DEPTH);
        haz   = (q.size() > 0) && (q[0].ap || (q[0].bp && !q[0].ui)) && !fwd_ok;
        m_iss = (q.size() > 0) && wb_ready && !haz;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            fl.delete();
            last_res = '0;
            m_op = '0; m_a = '0; m_b = '0;
            m_acc = 1'b0;
            m_iss = 1'b0;
        end else begin
            if (m_iss) begin
                h  = q.pop_front();
                av = h.ap ? last_res : h.a;
                bv = h.ui ? ext(h.imm) : (h.bp ? last_res : h.b);
                m_op = h.op; m_a = av; m_b = bv;
                e.cyc  = cyc;
                e.rd   = h.rd;
                e.div0 = (h.op == 4'd3 || h.op == 4'd15) && (bv == '0);
                e.res  = av + bv + {68'd0, h.op};
                last_res = e.res;
                fl.push_back(e);
            end
            if (m_acc) q.push_back(cur);
        end
        #1;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [IMM_W-1:0] imm, input logic ui, input logic ap, input logic bp,
                          input logic [TAG_W-1:0] rd);
        in_op = op; in_a = a; in_b = b; in_imm = imm;
        in_use_imm = ui; in_a_pend = ap; in_b_pend = bp; in_rd = rd;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [IMM_W-1:0] imm, input logic ui, input logic ap, input logic bp,
                        input logic [TAG_W-1:0] rd);
        bit got;
        got = 1'b0;
        set_in(op, a, b, imm, ui, ap, bp, rd);
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = m_acc;
        end
        if (!got) timeout_fail("send_accept");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            done = (q.size() == 0) && (fl.size() == 0 || fl[fl.size()-1].cyc + 1 < cyc);
            if (!done) step();
        end
        if (!done) timeout_fail("drain");
    endtask

    task automatic rand_inputs();
        logic [95:0] ra;
        logic [95:0] rb;
        logic [63:0] ri;
        ra = {$urandom(), $urandom(), $urandom()};
        rb = {$urandom(), $urandom(), $urandom()};
        ri = {$urandom(), $urandom()};
        in_valid   = ($urandom_range(0, 3) != 0);
        in_op      = 4'($urandom_range(0, 15));
        in_a       = ra[DATA_W-1:0];
        in_b       = ($urandom_range(0, 7) == 0) ? '0 : rb[DATA_W-1:0];
        in_imm     = ($urandom_range(0, 7) == 0) ? '0 : ri[IMM_W-1:0];
        in_use_imm = ($urandom_range(0, 2) == 0);
        in_a_pend  = ($urandom_range(0, 2) == 0);
        in_b_pend  = ($urandom_range(0, 2) == 0);
        in_rd      = 5'($urandom_range(0, 31));
        wb_ready   = ($urandom_range(0, 3) != 0);
        rst        = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        // Power-up reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle(1);

        // Basic issue: A=5, B=7 -> C=12
        wb_ready = 1'b1;
        send(4'd0, 72'd5, 72'd7, '0, 1'b0, 1'b0, 1'b0, 5'd1);
        drain();
        chk("basic_c", alu_c, 72'd12);

        // Dependent op: one bubble, forwarded A=12, B=3
        send(4'd0, 72'd5, 72'd7, '0, 1'b0, 1'b0, 1'b0, 5'd2);
        send(4'd0, 72'd99, 72'd3, '0, 1'b0, 1'b1, 1'b0, 5'd3);
        drain();
        chk("dep_a", alu_a, 72'd12);
        chk("dep_b", alu_b, 72'd3);

        // Fill with wb_ready low; fifth op waits for space, order across wrap
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'(i), 72'(10 + i), 72'(20 + i), '0, 1'b0, 1'b0, 1'b0, 5'(10 + i));
        set_in(4'd4, 72'd14, 72'd24, '0, 1'b0, 1'b0, 1'b0, 5'd14);
        repeat (3) step();
        wb_ready = 1'b1;
        send(4'd4, 72'd14, 72'd24, '0, 1'b0, 1'b0, 1'b0, 5'd14);
        drain();

        // Divide-by-zero flag cases
        send(4'd3,  72'd10, 72'd0, '0, 1'b0, 1'b0, 1'b0, 5'd20);
        send(4'd15, 72'd10, 72'd5, '0, 1'b1, 1'b0, 1'b0, 5'd21);
        send(4'd3,  72'd10, 72'd4, '0, 1'b0, 1'b0, 1'b0, 5'd22);
        drain();

        // Immediate extension of the top immediate bit
        send(4'd0, 72'd1, 72'd2, 55'h40_0000_0000_0000, 1'b1, 1'b0, 1'b0, 5'd7);
        drain();
`ifdef ALU_ISSUE_IMM_SEXT_EN
        chk("imm_ext", alu_b, 72'hFF_FFC0_0000_0000_0000);
`else
        chk("imm_ext", alu_b, 72'h00_0040_0000_0000_0000);
`endif

        // Reset mid-stream with three queued ops
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd1, 72'(i), 72'(i), '0, 1'b0, 1'b0, 1'b0, 5'(25 + i));
        wb_ready = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle(6);
        chk("rst_busy", 72'(busy), 72'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end
        rst = 1'b0;
        wb_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand issue stage directly upstream of the 72-bit ALU.
- Buffers decoded operations in a small FIFO and selects operand B (register value or 55-bit immediate).
- Resolves a back-to-back dependency on the previous result by stalling and forwarding the ALU's C output.
- Drives the ALU's op/A/B inputs and emits a result-valid/tag/div-by-zero sideband aligned with the ALU's registered C.

Parameters:
- DATA_W, 72, operand and result width.
- IMM_W, 55, immediate width.
- TAG_W, 5, destination register tag width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  FIFO can accept.
- in_op  in  4  ALU opcode, 0-15.
- in_a  in  DATA_W  operand A value.
- in_b  in  DATA_W  operand B register value.
- in_imm  in  IMM_W  immediate.
- in_use_imm  in  1  B := extended in_imm.
- in_a_pend  in  1  A depends on the previous op's result.
- in_b_pend  in  1  B depends on the previous op's result (ignored when in_use_imm=1).
- in_rd  in  TAG_W  destination tag.
- wb_ready  in  1  downstream permits a new issue.
- alu_c  in  DATA_W  ALU result C.
- alu_op  out  4  to ALU op.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- res_valid  out  1  alu_c holds the result of an issued op this cycle.
- res_rd  out  TAG_W  tag of that result.
- res_div0  out  1  that op was div (3) or rem (15) with B==0.
- busy  out  1  FIFO non-empty or op in flight.

Behaviour:
- Reset: clk and rst only, synchronous; rst sampled high at a rising edge clears everything.
  - Reset values: alu_op=0, alu_a=0, alu_b=0, res_valid=0, res_rd=0, res_div0=0, busy=0, in_ready=1.
  - FIFO pointers, count, in-flight pipeline and last_c_q are all cleared.
  - Reset mid-operation discards queued and in-flight ops; no res_valid follows.
- Enqueue: on in_valid && in_ready.
  - in_ready = (count < DEPTH) and does not depend on in_valid.
  - Enqueue into a full FIFO is impossible; a simultaneous enqueue+issue when full is not accepted that cycle.
- Issue condition (head, count>0): wb_ready && no hazard.
  - Hazard = (a_pend || (b_pend && !use_imm)) && !fwd_ok.
  - fwd_ok = (inflight==0) || (inflight==1 && res_valid).
- Issue edge E:
  - alu_op/alu_a/alu_b registers load the head op and operands; the FIFO pops.
  - Operands: A = a_pend ? fwd : in_a; B = use_imm ? ext(imm) : (b_pend ? fwd : in_b).
  - fwd = res_valid ? alu_c : last_c_q.
  - ext = zero-extend unless the optional feature is enabled.
  - When no issue occurs, alu_* hold their values; the ALU recomputes the same C harmlessly.
- Latency:
  - The ALU samples at E+1.
  - res_valid is high for exactly the cycle between E+1 and E+2, with res_rd/res_div0 of that op.
  - Implement as a 2-stage valid/tag pipe.
  - A dependent op issues no earlier than E+2, giving exactly one bubble.
- inflight: 0..2.
  - Increments on issue, decrements when res_valid; simultaneous issue and res_valid leave it unchanged.
- last_c_q: loads alu_c on every cycle where res_valid=1.
- res_div0: (op==3 || op==15) && effective B==0, computed at issue, carried in the pipe.
- Back-to-back independent ops issue one per cycle at full throughput.
- A pend bit on the first op after reset or after the pipe drains: inflight==0, so fwd=last_c_q (0 after reset).
- The FIFO pointers wrap modulo DEPTH.
- busy = (count!=0) || (inflight!=0).

Optional Feature:
- Macro: ALU_ISSUE_IMM_SEXT_EN.
- Defined: ext(imm) sign-extends in_imm[IMM_W-1] to DATA_W.
- Undefined: ext(imm) zero-extends.
- No other behaviour changes.

Test Plan:
- rst high 2 cycles mid-stream with 3 queued ops -> all outputs 0, in_ready=1, busy=0, no res_valid afterwards.
- Enqueue op0 A=5 B=7 with wb_ready=1, stub ALU computing C=A+B registered -> alu_op=0/a=5/b=7 after E; res_valid=1 with alu_c=12 at the cycle after E+1, res_rd matches.
- op0 A=5 B=7, then op1 with a_pend=1, in_b=3 -> one bubble; op1 issues at E+2 with alu_a=12, alu_b=3.
- Enqueue 5 ops with wb_ready=0, DEPTH=4 -> in_ready drops after 4 ops; the 5th is held until the first issue after wb_ready=1; FIFO order preserved across wrap.
- op3 with B=0, then op15 with use_imm=1 and imm=0 -> res_div0=1 for both; op3 with B=4 -> res_div0=0.
- use_imm=1, imm=55'h40_0000_0000_0000 -> alu_b=72'h00_0040_0000_0000_0000, or 72'hFF_FFC0_0000_0000_0000 with ALU_ISSUE_IMM_SEXT_EN.
